// File: rtl/clus_pass_seq.sv
// rtl/clus_pass_seq.sv - multi-pass PE cluster sequencer with psum accumulation and drain port
module clus_pass_seq #(
  parameter int DATA_BITWIDTH    = 16,
  parameter int X_dim            = 3,
  parameter int NUM_CIN          = 4,
  parameter int WGHT_LOAD_CYCLES = 9,
  parameter int IACT_LOAD_CYCLES = 144
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             load_spad_ctrl_wght,
  output logic                             load_spad_ctrl_iact,
  output logic                             pe_start,
  input  logic                             load_done,
  input  logic                             compute_done,
  input  logic [DATA_BITWIDTH*X_dim-1:0]   pe_out,
  output logic [$clog2(NUM_CIN):0]         pass_idx,
  output logic                             psum_valid,
  input  logic                             psum_ready,
  output logic [DATA_BITWIDTH-1:0]         psum_data,
  output logic [$clog2(X_dim):0]           psum_idx
);

  localparam int PASS_W  = $clog2(NUM_CIN) + 1;
  localparam int IDX_W   = $clog2(X_dim) + 1;
  localparam int CNT_MAX = (WGHT_LOAD_CYCLES > IACT_LOAD_CYCLES) ? WGHT_LOAD_CYCLES : IACT_LOAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  W_LAST    = CNT_W'(WGHT_LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  I_LAST    = CNT_W'(IACT_LOAD_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_CIN - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(X_dim - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    LOAD_I  = 3'd2,
    WAIT_LD = 3'd3,
    RUN     = 3'd4,
    DRAIN   = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t                   state, state_d;
  logic [CNT_W-1:0]         cnt, cnt_d;
  logic [PASS_W-1:0]        pass_idx_d;
  logic                     wght_d, iact_d, pe_start_d, busy_d, done_d;
  logic                     psum_valid_d;
  logic [DATA_BITWIDTH-1:0] psum_data_d;
  logic [IDX_W-1:0]         psum_idx_d;
  logic                     cd_prev;
  logic                     capture;
  logic [DATA_BITWIDTH-1:0] acc     [X_dim];
  logic [DATA_BITWIDTH-1:0] acc_nxt [X_dim];
  logic [DATA_BITWIDTH-1:0] drain_sel;

  // Candidate bank contents for this pass: first pass loads, later passes add (wrapping)
  always_comb begin
    for (int i = 0; i < X_dim; i++) begin
      if (pass_idx == '0) begin
        acc_nxt[i] = pe_out[i*DATA_BITWIDTH +: DATA_BITWIDTH];
      end else begin
        acc_nxt[i] = acc[i] + pe_out[i*DATA_BITWIDTH +: DATA_BITWIDTH];
      end
    end
  end

  // Bank word that follows the one currently presented on the drain port
  always_comb begin
    drain_sel = '0;
    for (int i = 0; i < X_dim; i++) begin
      if (IDX_W'(i) == psum_idx + IDX_W'(1)) begin
        drain_sel = acc[i];
      end
    end
  end

  // Next-state and next-output decode; pulses default low, everything else holds
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    pass_idx_d   = pass_idx;
    wght_d       = 1'b0;
    iact_d       = 1'b0;
    pe_start_d   = 1'b0;
    done_d       = 1'b0;
    psum_valid_d = 1'b0;
    psum_data_d  = psum_data;
    psum_idx_d   = psum_idx;
    capture      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_d    = LOAD_W;
          pass_idx_d = '0;
          cnt_d      = '0;
          wght_d     = 1'b1;
        end
      end
      LOAD_W: begin
        if (cnt == W_LAST) begin
          state_d = LOAD_I;
          cnt_d   = '0;
          iact_d  = 1'b1;
        end else begin
          cnt_d  = cnt + CNT_W'(1);
          wght_d = 1'b1;
        end
      end
      LOAD_I: begin
        if (cnt == I_LAST) begin
          state_d = WAIT_LD;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt + CNT_W'(1);
          iact_d = 1'b1;
        end
      end
      WAIT_LD: begin
        if (load_done) begin
          state_d    = RUN;
          pe_start_d = 1'b1;
        end
      end
      RUN: begin
        // Only a fresh low->high edge counts; a level left over from the last pass is ignored
        if (compute_done && !cd_prev) begin
          capture = 1'b1;
          if (pass_idx == PASS_LAST) begin
            state_d      = DRAIN;
            psum_idx_d   = '0;
            psum_valid_d = 1'b1;
            psum_data_d  = acc_nxt[0];
          end else begin
            state_d    = LOAD_W;
            pass_idx_d = pass_idx + PASS_W'(1);
            cnt_d      = '0;
            wght_d     = 1'b1;
          end
        end
      end
      DRAIN: begin
        psum_valid_d = 1'b1;
        if (psum_ready) begin
          if (psum_idx == IDX_LAST) begin
            state_d      = DONE;
            psum_valid_d = 1'b0;
            psum_data_d  = '0;
            done_d       = 1'b1;
          end else begin
            psum_idx_d  = psum_idx + IDX_W'(1);
            psum_data_d = drain_sel;
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        psum_idx_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      pass_idx            <= '0;
      load_spad_ctrl_wght <= 1'b0;
      load_spad_ctrl_iact <= 1'b0;
      pe_start            <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      psum_valid          <= 1'b0;
      psum_data           <= '0;
      psum_idx            <= '0;
      cd_prev             <= 1'b0;
    end else begin
      state               <= state_d;
      cnt                 <= cnt_d;
      pass_idx            <= pass_idx_d;
      load_spad_ctrl_wght <= wght_d;
      load_spad_ctrl_iact <= iact_d;
      pe_start            <= pe_start_d;
      busy                <= busy_d;
      done                <= done_d;
      psum_valid          <= psum_valid_d;
      psum_data           <= psum_data_d;
      psum_idx            <= psum_idx_d;
      cd_prev             <= compute_done;
    end
  end

  // Psum bank: all columns captured together on the compute_done edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < X_dim; i++) begin
        acc[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < X_dim; i++) begin
        acc[i] <= acc_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_clus_pass_seq.sv
// tb/tb_clus_pass_seq.sv - self-checking bench for clus_pass_seq
module tb_clus_pass_seq;

  localparam int DB = 16;
  localparam int XD = 3;
  localparam int NC = 2;
  localparam int WL = 2;
  localparam int IL = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done, load_spad_ctrl_wght, load_spad_ctrl_iact, pe_start;
  logic          load_done, compute_done;
  logic [DB*XD-1:0] pe_out;
  logic [1:0]    pass_idx;
  logic          psum_valid, psum_ready;
  logic [DB-1:0] psum_data;
  logic [2:0]    psum_idx;

  clus_pass_seq #(
    .DATA_BITWIDTH(DB), .X_dim(XD), .NUM_CIN(NC),
    .WGHT_LOAD_CYCLES(WL), .IACT_LOAD_CYCLES(IL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .load_spad_ctrl_wght(load_spad_ctrl_wght), .load_spad_ctrl_iact(load_spad_ctrl_iact),
    .pe_start(pe_start), .load_done(load_done), .compute_done(compute_done),
    .pe_out(pe_out), .pass_idx(pass_idx), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .psum_data(psum_data), .psum_idx(psum_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] data;
  } exp_t;

  typedef struct packed {
    logic [47:0] p0;        // {col2, col1, col0}
    logic [47:0] p1;
    logic [47:0] expd;
    logic [7:0]  ready_pat; // LSB first, one bit per drain cycle, 1 after exhausted
    logic        hold;      // keep compute_done high across the pass boundary
    logic [7:0]  drain_cycles;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];
  int   wght_cyc = 0, iact_cyc = 0, pst_cyc = 0, drain_cyc = 0, done_cnt = 0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic [2:0]  prev_idx = '0;
  vec_t vecs[3];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Negedge sampling: scoreboard pops, stall stability and activity counters
  task automatic sample();
    exp_t e;
    if (load_spad_ctrl_wght) wght_cyc++;
    if (load_spad_ctrl_iact) iact_cyc++;
    if (pe_start) pst_cyc++;
    if (psum_valid) drain_cyc++;
    if (done) done_cnt++;
    check("ctrl_exclusive", {47'd0, load_spad_ctrl_wght & load_spad_ctrl_iact}, 48'd0);
    if (prev_stall) begin
      check("hold_data", {32'd0, psum_data}, {32'd0, prev_data});
      check("hold_idx", {45'd0, psum_idx}, {45'd0, prev_idx});
    end
    if (psum_valid && psum_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_word", 48'd1, 48'd0);
      end else begin
        e = sbq.pop_front();
        check("psum_idx", {45'd0, psum_idx}, {45'd0, e.idx});
        check("psum_data", {32'd0, psum_data}, {32'd0, e.data});
      end
    end
    prev_stall = psum_valid && !psum_ready;
    prev_data  = psum_data;
    prev_idx   = psum_idx;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pe_start();
    for (int t = 0; t < 100 && !pe_start; t++) tick();
    check("pe_start_seen", {47'd0, pe_start}, 48'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int w0, i0, p0, d0, dn0, k;
    w0 = wght_cyc; i0 = iact_cyc; p0 = pst_cyc; d0 = drain_cyc; dn0 = done_cnt;
    for (int c = 0; c < XD; c++) begin
      sbq.push_back('{idx: 3'(c), data: v.expd[c*16 +: 16]});
    end
    psum_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wght_rises", {47'd0, load_spad_ctrl_wght}, 48'd1);
    check("busy_after_start", {47'd0, busy}, 48'd1);
    check("pass_idx_start", {46'd0, pass_idx}, 48'd0);
    for (int p = 0; p < NC; p++) begin
      wait_pe_start();
      check("pass_idx", {46'd0, pass_idx}, 48'(p));
      pe_out = (p == 0) ? v.p0 : v.p1;
      if (p == 1 && v.hold) begin
        for (int t = 0; t < 4; t++) tick();
        check("hold_no_capture", {44'd0, busy, psum_valid, pass_idx}, {44'd0, 1'b1, 1'b0, 2'd1});
        compute_done = 1'b0;
        tick();
      end
      tick();
      compute_done = 1'b1;
      tick();
      if (!(v.hold && p == 0)) compute_done = 1'b0;
    end
    k = 0;
    for (int t = 0; t < 50 && !done; t++) begin
      if (psum_valid) begin
        psum_ready = (k < 8) ? v.ready_pat[k] : 1'b1;
        k++;
      end
      tick();
    end
    check("done_pulse", {46'd0, done, busy}, {46'd0, 1'b1, 1'b1});
    psum_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_in_done", {45'd0, done, busy, load_spad_ctrl_wght}, 48'd0);
    check("wght_cycles", 48'(wght_cyc - w0), 48'(WL * NC));
    check("iact_cycles", 48'(iact_cyc - i0), 48'(IL * NC));
    check("pe_start_cycles", 48'(pst_cyc - p0), 48'(NC));
    check("drain_cycles", 48'(drain_cyc - d0), {40'd0, v.drain_cycles});
    check("done_count", 48'(done_cnt - dn0), 48'd1);
    check("scoreboard_empty", 48'(sbq.size()), 48'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dn0;
    vecs[0] = '{p0: {16'd3, 16'd2, 16'd1}, p1: {16'd30, 16'd20, 16'd10},
                expd: {16'd33, 16'd22, 16'd11}, ready_pat: 8'hFF, hold: 1'b0, drain_cycles: 8'd3};
    vecs[1] = '{p0: {16'h8000, 16'd5, 16'hFFFF}, p1: {16'h8000, 16'd7, 16'h0002},
                expd: {16'h0000, 16'd12, 16'h0001}, ready_pat: 8'h19, hold: 1'b0, drain_cycles: 8'd5};
    vecs[2] = '{p0: {16'd300, 16'd200, 16'd100}, p1: {16'd1, 16'd1, 16'd1},
                expd: {16'd301, 16'd201, 16'd101}, ready_pat: 8'h15, hold: 1'b1, drain_cycles: 8'd5};

    reset = 1'b0; start = 1'b0; load_done = 1'b1; compute_done = 1'b0;
    psum_ready = 1'b0; pe_out = '0;
    tick();
    tick();
    check("reset_state",
          {28'd0, busy, done, load_spad_ctrl_wght, load_spad_ctrl_iact, pe_start, pass_idx,
           psum_valid, psum_idx, psum_data},
          48'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) run_vec(vecs[i]);

    // Abort during LOAD_I of pass 1, then a clean rerun
    dn0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pe_start();
    pe_out = vecs[1].p0;
    tick();
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    for (int t = 0; t < 100 && !(pass_idx == 2'd1 && load_spad_ctrl_iact); t++) tick();
    check("reached_pass1_iact", {46'd0, pass_idx == 2'd1, load_spad_ctrl_iact}, 48'd3);
    reset = 1'b0;
    #1;
    check("abort_outputs_zero",
          {28'd0, busy, done, load_spad_ctrl_wght, load_spad_ctrl_iact, pe_start, pass_idx,
           psum_valid, psum_idx, psum_data},
          48'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_no_done", 48'(done_cnt - dn0), 48'd0);
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
